// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
//   Turns one-clock event strobes into LED blinks that are long enough to see.
//   Each blink is a minimum ON phase followed by a minimum dark GAP phase.
//   Events that arrive during a blink are counted and replayed one blink each.
//
//   The build option PULSE_SYNC_EN makes i_pulse an asynchronous level input.
//   It is then passed through a 2-flop synchronizer and a registered rising-edge
//   detector, so each low->high transition is one event (adds 3 clocks latency).
//   When PULSE_SYNC_EN is not defined, every high cycle of i_pulse is one event.
//
// Parameters
//   TICK_MAX  : prescaler terminal count, one tick every TICK_MAX+1 clocks
//   ON_TICKS  : ticks the LED stays lit per blink (>= 1)
//   GAP_TICKS : ticks the LED stays dark after each blink (>= 1)
//   PEND_W    : width of the pending-event counter (saturating)
//
// Ports
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   i_pulse : event strobe (or async level with PULSE_SYNC_EN)
//   o_led   : stretched LED drive, registered
//   o_busy  : blink in progress or events pending, registered
//   o_drop  : one-cycle strobe when an event is lost at saturation, registered
// -----------------------------------------------------------------------------
module pulse_stretch #(
  parameter int unsigned TICK_MAX  = 249999,
  parameter int unsigned ON_TICKS  = 2,
  parameter int unsigned GAP_TICKS = 2,
  parameter int unsigned PEND_W    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pulse,
  output logic o_led,
  output logic o_busy,
  output logic o_drop
);

  localparam int unsigned PRE_W     = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam int unsigned MAX_TICKS = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                led_q, busy_q, drop_q;
  logic                drop_d;
  logic                tick_c;
  logic                ev_c;
  logic                inc_c, dec_c;
  logic [CNT_W-1:0]    cnt_inc_c;

  // ---------------------------------------------------------------------------
  // Event source
  // ---------------------------------------------------------------------------
`ifdef PULSE_SYNC_EN
  logic sync1_q, sync2_q, sync3_q, edge_q;

  // Two-flop synchronizer, delayed copy for edge detection, registered edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= i_pulse;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  assign ev_c = edge_q;
`else
  assign ev_c = i_pulse;
`endif

  // ---------------------------------------------------------------------------
  // Free-running prescaler; never realigned by events, so a phase's first tick
  // may come early.
  // ---------------------------------------------------------------------------
  assign tick_c = (pre_q == PRE_W'(TICK_MAX));

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (tick_c) begin
      pre_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, tick counting and pending-event accounting
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    drop_d    = 1'b0;
    cnt_inc_c = cnt_q + CNT_W'(1);

    // A pulse that starts a blink straight from an empty idle is not queued.
    inc_c = ev_c && !((state_q == ST_IDLE) && (pend_q == '0));
    // Idle with work queued: consume one queued event to start the next blink.
    dec_c = (state_q == ST_IDLE) && (pend_q != '0);

    case (state_q)
      ST_IDLE: begin
        if (ev_c || (pend_q != '0)) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        if (tick_c) begin
          if (cnt_inc_c == CNT_W'(ON_TICKS)) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end
      ST_GAP: begin
        if (tick_c) begin
          if (cnt_inc_c == CNT_W'(GAP_TICKS)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Simultaneous inc and dec cancel; a full counter drops the new event.
    if (inc_c && !dec_c) begin
      if (pend_q == {PEND_W{1'b1}}) begin
        drop_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (dec_c && !inc_c) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      pre_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pre_q   <= pre_d;
      led_q   <= (state_d == ST_ON);
      busy_q  <= (state_d != ST_IDLE) || (pend_d != '0);
      drop_q  <= drop_d;
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;
  assign o_drop = drop_q;

endmodule
